program_loader: RTL
===================

# program_loader

Boot-time loader that fills the writable program memory from a byte stream, such as a UART receiver, and holds the core in reset until the image is in place. It sits between the byte source and the program memory write port, and drives the core's reset. It assembles little-endian bytes into instruction words and writes them at word-aligned byte addresses, the same addressing the fetch path uses. It releases the core only after a complete, length-checked image has been written.

## Interface
Parameters:
- MEMORY_DEPTH, 32, program memory depth in words; must be 1..255.
- DATA_WIDTH, 32, instruction/address width; fixed at 32 (four bytes per word).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start_i  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR.
- Byte_Valid_i  input  1  Byte_Data_i is valid.
- Byte_Data_i  input  8  stream byte.
- Byte_Ready_o  output  1  loader accepts a byte this cycle.
- Mem_Write_Enable_o  output  1  program memory write strobe, one cycle per word.
- Mem_Address_o  output  DATA_WIDTH  byte address of the word written: word_index*4.
- Mem_Write_Data_o  output  DATA_WIDTH  assembled instruction word.
- Core_Reset_n_o  output  1  active-low reset to the core; low except in DONE.
- Load_Done_o  output  1  image loaded; high in DONE.
- Error_o  output  1  bad length byte; high in ERROR.

## Operation
- A byte is accepted on a rising clk when Byte_Valid_i=1 and Byte_Ready_o=1.
- Stream format:
  - First byte is N, the word count.
  - Then 4N bytes follow, least-significant byte first.
  - Byte k of a word (k=0..3) lands in bits [8k+7:8k].
- Internal registers:
  - word_index, clog2(MEMORY_DEPTH)+1 bits.
  - byte_cnt, 2 bits.
  - N, 8 bits.
  - Assembly register, 32 bits.
- States:
  - IDLE: Byte_Ready_o=0, Core_Reset_n_o=0. Start_i -> LEN.
  - LEN: Byte_Ready_o=1. Accepted byte is stored as N.
    - N=0 or N>MEMORY_DEPTH -> ERROR.
    - Otherwise word_index=0, byte_cnt=0 -> DATA.
  - DATA: Byte_Ready_o=1. Each accepted byte is placed in its lane and byte_cnt increments (wraps 3->0). The 4th byte -> WRITE.
  - WRITE: Byte_Ready_o=0. Mem_Write_Enable_o=1, with Mem_Address_o={word_index,2'b00} zero-extended and Mem_Write_Data_o=assembled word.
    - word_index increments.
    - If word_index+1==N -> DONE, else -> DATA.
  - DONE: Load_Done_o=1, Core_Reset_n_o=1, Byte_Ready_o=0. Start_i -> LEN; Core_Reset_n_o drops in the same transition.
  - ERROR: Error_o=1, Core_Reset_n_o=0, Byte_Ready_o=0. Start_i -> LEN and clears Error_o.
- Bytes presented while Byte_Ready_o=0 are not consumed. The source must hold them, valid/ready style.
- Start_i in LEN, DATA or WRITE is ignored; a load cannot be aborted except by reset.
- Memory words not written keep their previous contents; the loader never clears memory.

## Timing
- Reset values, taken asynchronously on reset low: state=IDLE, Byte_Ready_o=0, Mem_Write_Enable_o=0, Mem_Address_o=0, Mem_Write_Data_o=0, Core_Reset_n_o=0, Load_Done_o=0, Error_o=0.
- All outputs are registered, or decoded from the state register only; no combinational path from inputs to outputs.
- Start_i sampled at edge t: Byte_Ready_o=1 from cycle t+1.
- Latency: the 4th byte accepted at edge t gives WRITE, and hence Mem_Write_Enable_o, during cycle t+1. Byte_Ready_o returns high in cycle t+2 if more words remain.
- Throughput: at most 4 bytes per 5 cycles.
- Final write in cycle t leads to DONE in cycle t+1: Core_Reset_n_o and Load_Done_o rise together.
- A bad length byte accepted at edge t gives Error_o=1 in cycle t+1. No memory write occurs.
- Reset asserted mid-load: immediate return to IDLE and the core stays in reset. A partially written image is left in memory.

## Test plan
- Reset then idle: all outputs at reset values; Byte_Valid_i=1 with no Start_i -> no byte consumed and no write.
- Start, N=1, bytes 13,05,00,00 -> one write: address 0x0, data 0x00000513; then Load_Done_o=1, Core_Reset_n_o=1.
- Start, N=3, 12 bytes with random valid gaps -> writes at 0x0, 0x4, 0x8 with the correct little-endian words; Byte_Ready_o=0 in each WRITE cycle; exactly 3 write strobes.
- N=0, then separately N=MEMORY_DEPTH+1 -> Error_o=1, no write, Core_Reset_n_o=0; Start_i then N=1 recovers to DONE.
- Reset asserted after 2 bytes of word 1 (N=2) -> IDLE at once, Core_Reset_n_o=0; a fresh load succeeds.
- In DONE, a Start_i pulse -> Core_Reset_n_o=0 and Load_Done_o=0 next cycle; Start_i pulses during DATA are ignored.

Source files
------------

// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes it into program
// memory word by word, and holds the core in reset until the whole image has been written.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic                  Byte_Valid_i,
  input  logic [7:0]            Byte_Data_i,
  output logic                  Byte_Ready_o,
  output logic                  Mem_Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  output logic                  Core_Reset_n_o,
  output logic                  Load_Done_o,
  output logic                  Error_o
);

  localparam int unsigned IdxW = $clog2(MEMORY_DEPTH) + 1;

  typedef enum logic [2:0] {StIdle, StLen, StData, StWrite, StDone, StError} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       word_index_q;
  logic [1:0]            byte_cnt_q;
  logic [7:0]            n_q;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_d;
  logic                  ready_q, we_q, core_rst_n_q, done_q, error_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic                  len_bad;
  logic                  last_word;

  // Incoming byte dropped into its lane of the assembly register.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_cnt_q, 3'b000} +: 8] = Byte_Data_i;
  end

  assign len_bad   = (Byte_Data_i == 8'd0) || (32'(Byte_Data_i) > MEMORY_DEPTH);
  assign last_word = (32'(word_index_q) + 32'd1) == 32'(n_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      word_index_q <= '0;
      byte_cnt_q   <= '0;
      n_q          <= '0;
      asm_q        <= '0;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Start_i) begin
            state_q <= StLen;
            ready_q <= 1'b1;
          end
        end
        StLen: begin
          if (Byte_Valid_i) begin
            n_q <= Byte_Data_i;
            if (len_bad) begin
              state_q <= StError;
              ready_q <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q      <= StData;
              word_index_q <= '0;
              byte_cnt_q   <= '0;
            end
          end
        end
        StData: begin
          if (Byte_Valid_i) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q <= StWrite;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= DATA_WIDTH'({word_index_q, 2'b00});
              wdata_q <= asm_d;
            end
          end
        end
        StWrite: begin
          we_q         <= 1'b0;
          word_index_q <= word_index_q + 1'b1;
          if (last_word) begin
            state_q      <= StDone;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end else begin
            state_q <= StData;
            ready_q <= 1'b1;
          end
        end
        StDone: begin
          if (Start_i) begin
            state_q      <= StLen;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
          end
        end
        StError: begin
          if (Start_i) begin
            state_q <= StLen;
            ready_q <= 1'b1;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          ready_q      <= 1'b0;
          we_q         <= 1'b0;
          core_rst_n_q <= 1'b0;
          done_q       <= 1'b0;
          error_q      <= 1'b0;
        end
      endcase
    end
  end

  assign Byte_Ready_o       = ready_q;
  assign Mem_Write_Enable_o = we_q;
  assign Mem_Address_o      = addr_q;
  assign Mem_Write_Data_o   = wdata_q;
  assign Core_Reset_n_o     = core_rst_n_q;
  assign Load_Done_o        = done_q;
  assign Error_o            = error_q;

endmodule
